// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizing constants for the 32x64 register file
package regfile_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam int ZERO_REG = 31;
endpackage

// File: rtl/decoder5_32.sv
// rtl/decoder5_32.sv - gated 5-to-32 one-hot write-enable decoder
// A 2-to-4 stage picks a bank of eight, each bank is a 3-to-8 decoder.
module decoder2_4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);
  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end
endmodule

module decoder3_8 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);
  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end
endmodule

module decoder5_32
  import regfile_pkg::*;
(
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   WriteRegister,
  output logic [NUM_REGS-1:0] dec_out
);
  logic [3:0] bank_en;

  decoder2_4 u_bank (
    .en (RegWrite),
    .a  (WriteRegister[4:3]),
    .y  (bank_en)
  );

  for (genvar g = 0; g < 4; g++) begin : g_bank
    decoder3_8 u_dec (
      .en (bank_en[g]),
      .a  (WriteRegister[2:0]),
      .y  (dec_out[g*8 +: 8])
    );
  end
endmodule

// File: rtl/mux32_64.sv
// rtl/mux32_64.sv - read-select mux hierarchy: one 32:1 mux per data bit
module mux32_1 (
  input  logic [31:0] d,
  input  logic [4:0]  sel,
  output logic        y
);
  assign y = d[sel];
endmodule

module mux32_64
  import regfile_pkg::*;
(
  input  logic [NUM_REGS-1:0][DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0]               sel,
  output logic [DATA_W-1:0]               data_out
);
  for (genvar b = 0; b < DATA_W; b++) begin : g_bit
    logic [NUM_REGS-1:0] col;

    always_comb begin
      col = '0;
      for (int r = 0; r < NUM_REGS; r++) col[r] = data_in[r][b];
    end

    mux32_1 u_mux (
      .d   (col),
      .sel (sel),
      .y   (data_out[b])
    );
  end
endmodule

// File: rtl/regfile32x64.sv
// rtl/regfile32x64.sv - 32x64 register file, two read ports, one write port
// Register ZERO_REG is hardwired to zero; writes bypass to same-cycle reads.
module regfile32x64 #(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0]             we_onehot;
  logic [NUM_REGS-1:0]             we_mask;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic [DATA_W-1:0]               stored1;
  logic [DATA_W-1:0]               stored2;
  logic                            wr_live;

  decoder5_32 u_dec (
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .dec_out       (we_onehot)
  );

  always_comb begin
    we_mask           = we_onehot;
    we_mask[ZERO_REG] = 1'b0;
    regs_d            = regs_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (we_mask[r]) regs_d[r] = WriteData;
    end
  end

  // Reset wins over a coincident write, which is simply dropped.
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  mux32_64 u_rd1 (
    .data_in  (regs_q),
    .sel      (ReadRegister1),
    .data_out (stored1)
  );

  mux32_64 u_rd2 (
    .data_in  (regs_q),
    .sel      (ReadRegister2),
    .data_out (stored2)
  );

  assign wr_live = RegWrite && !reset && (WriteRegister != ADDR_W'(ZERO_REG));

  always_comb begin
    ReadData1 = stored1;
    if (ReadRegister1 == ADDR_W'(ZERO_REG))                    ReadData1 = '0;
    else if (wr_live && (ReadRegister1 == WriteRegister))      ReadData1 = WriteData;

    ReadData2 = stored2;
    if (ReadRegister2 == ADDR_W'(ZERO_REG))                    ReadData2 = '0;
    else if (wr_live && (ReadRegister2 == WriteRegister))      ReadData2 = WriteData;
  end
endmodule
